multi_word_add_seq: RTL
=======================

# multi_word_add_seq

Sequencer that performs N-word add, subtract and add-with-carry by driving a shared nrOfBits-wide Adder one word per cycle. It sits directly around the Adder. Upstream, it feeds dataA, dataB and carryIn from latched operand registers. Downstream, it consumes result and carryOut, collecting the words into a full-width result with carry, signed-overflow and zero flags.

## Interface
- nrOfBits, 16, width of the external Adder and of one word
- nrOfWords, 2, words per operation (≥1); W = nrOfBits*nrOfWords
- clock  in  1  system clock, all state on rising edge
- resetN  in  1  asynchronous, active-low reset
- startValid  in  1  operation request
- startReady  out  1  sequencer can accept a request
- opA, opB  in  W  operands, sampled only on accept
- subtract  in  1  1: A − B − borrow; 0: A + B + carry
- carryInit  in  1  initial carry (add) or borrow (subtract)
- adderDataA, adderDataB  out  nrOfBits  to Adder dataA/dataB
- adderCarryIn  out  1  to Adder carryIn
- adderResult  in  nrOfBits  from Adder result
- adderCarryOut  in  1  from Adder carryOut
- resultValid  out  1  result and flags valid
- resultReady  in  1  consumer accepts result
- result  out  W  assembled sum/difference
- carryOut  out  1  raw carry out of top word (subtract: 1 = no borrow)
- overflow  out  1  signed overflow of full W-bit operation
- zero  out  1  result == 0

## Operation
- States: IDLE, RUN, DONE. Word index k counts 0..nrOfWords−1.
- IDLE:
  - startReady=1.
  - On startValid: latch opA and B' = subtract ? ~opB : opB.
  - Set carry register = subtract ? ~carryInit : carryInit.
  - Set k=0, go to RUN.
- RUN:
  - adderDataA = word k of latched A; adderDataB = word k of B'; adderCarryIn = carry register.
  - Each edge: write adderResult into result word k; carry register ← adderCarryOut; k ← k+1.
  - The edge that writes word nrOfWords−1 goes to DONE.
- Flags are captured on the top-word edge:
  - carryOut = adderCarryOut.
  - overflow = (A msb == B' msb) && (adderResult msb != A msb).
  - zero = all W result bits 0, including the word being written.
- DONE:
  - resultValid=1. result and flags are held stable.
  - On resultReady, go to IDLE. startReady is 0 in DONE, so there is no same-cycle re-accept.
- Outside RUN, adderDataA/B and adderCarryIn are driven 0.
- Operand inputs are ignored except on the accept edge. The Adder is combinational; the sequencer adds no bypass path.
- nrOfWords=1: RUN lasts one cycle.
- Reset (asynchronous, any state):
  - State=IDLE, k=0.
  - result, carryOut, overflow, zero, resultValid, carry and operand registers all 0.
  - startReady=1 while in reset and after release.
  - An operation in progress is discarded; there is no partial result.

## Timing
- Accept at edge E0. RUN spans the cycles after E0 through edge E0+nrOfWords.
- resultValid rises after edge E0+nrOfWords, a latency of nrOfWords cycles.
- Minimum request-to-request spacing is nrOfWords+2 cycles: accept, nrOfWords RUN cycles, one DONE cycle with resultReady=1, then IDLE.
- Adder outputs are sampled in the same cycle the operands are presented. The Adder path is single-cycle combinational.
- resultValid stays asserted and all result outputs hold while resultReady=0, for unlimited cycles.

## Test plan
- Carry propagation: nrOfBits=16, nrOfWords=2, add, opA=0x0001FFFF, opB=0x00000001, carryInit=0.
  - result=0x00020000, carryOut=0, overflow=0, zero=0.
  - resultValid exactly 2 cycles after accept; adderCarryIn=1 in the second RUN cycle.
- Wrap-around: add 0xFFFFFFFF + 0x00000001.
  - result=0x00000000, carryOut=1, zero=1, overflow=0.
- Subtract: 0x80000000 − 0x00000001, carryInit=0.
  - result=0x7FFFFFFF, carryOut=1, overflow=1.
- Add-with-carry: 0x7FFFFFFF + 0x00000000, carryInit=1.
  - result=0x80000000, overflow=1, carryOut=0.
- Backpressure:
  - Hold resultReady=0 for 5 cycles in DONE with startValid=1 and new operands. Outputs must stay stable, startReady=0, nothing accepted.
  - Raise resultReady: IDLE next cycle, then the new request is accepted.
- Reset mid-operation: assert resetN=0 during the second RUN cycle.
  - Immediately: resultValid=0, result=0, adderDataA/B=0, startReady=1.
  - After release, a fresh 0x00000002+0x00000003 gives result 0x00000005.

Source files
------------

// File: rtl/multi_word_add_seq.sv
// Word-serial add/subtract sequencer wrapped around an external combinational
// NR_OF_BITS-wide adder; assembles a full-width result with carry/overflow/zero.
module multi_word_add_seq #(
    parameter  int unsigned NR_OF_BITS  = 16,
    parameter  int unsigned NR_OF_WORDS = 2,
    localparam int unsigned W           = NR_OF_BITS * NR_OF_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [W-1:0]          op_a_i,
    input  logic [W-1:0]          op_b_i,
    input  logic                  subtract_i,
    input  logic                  carry_init_i,
    output logic [NR_OF_BITS-1:0] adder_data_a_o,
    output logic [NR_OF_BITS-1:0] adder_data_b_o,
    output logic                  adder_carry_in_o,
    input  logic [NR_OF_BITS-1:0] adder_result_i,
    input  logic                  adder_carry_out_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [W-1:0]          result_o,
    output logic                  carry_out_o,
    output logic                  overflow_o,
    output logic                  zero_o
);
    localparam int unsigned NB = NR_OF_BITS;
    localparam int unsigned NW = NR_OF_WORDS;
    localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_out_q, carry_out_d;
    logic            overflow_q, overflow_d;
    logic            zero_q, zero_d;

    logic [NB-1:0]   a_word [NW];
    logic [NB-1:0]   b_word [NW];
    logic            last_word;

    for (genvar gi = 0; gi < NW; gi++) begin : g_words
        assign a_word[gi] = a_q[gi*NB +: NB];
        assign b_word[gi] = b_q[gi*NB +: NB];
    end

    assign last_word = (k_q == KW'(NW - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        a_d              = a_q;
        b_d              = b_q;
        carry_d          = carry_q;
        result_d         = result_q;
        carry_out_d      = carry_out_q;
        overflow_d       = overflow_q;
        zero_d           = zero_q;
        start_ready_o    = 1'b0;
        result_valid_o   = 1'b0;
        adder_data_a_o   = '0;
        adder_data_b_o   = '0;
        adder_carry_in_o = 1'b0;

        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    // Subtraction runs as A + ~B + ~borrow through the same adder.
                    a_d     = op_a_i;
                    b_d     = subtract_i ? ~op_b_i : op_b_i;
                    carry_d = subtract_i ? ~carry_init_i : carry_init_i;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                adder_data_a_o   = a_word[k_q];
                adder_data_b_o   = b_word[k_q];
                adder_carry_in_o = carry_q;
                result_d[k_q*NB +: NB] = adder_result_i;
                carry_d = adder_carry_out_i;
                k_d     = k_q + 1'b1;
                if (last_word) begin
                    carry_out_d = adder_carry_out_i;
                    overflow_d  = (a_q[W-1] == b_q[W-1]) &&
                                  (adder_result_i[NB-1] != a_q[W-1]);
                    zero_d      = (result_d == '0);
                    k_d         = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result_o    = result_q;
    assign carry_out_o = carry_out_q;
    assign overflow_o  = overflow_q;
    assign zero_o      = zero_q;

endmodule
